// File: rtl/wb_obi_bridge_if.sv
// Signal bundle between an Ibex OBI-style request port and a Wishbone B4 bus.
// The master modport is the bridge's view: it answers the core and masters the bus.
// The slave modport is the complementary view (core plus Wishbone slave).
interface wb_obi_bridge_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32
);
    // Core side
    logic                   req;
    logic                   gnt;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [AddrWidth-1:0]   addr;
    logic [DataWidth-1:0]   wdata;
    logic                   rvalid;
    logic [DataWidth-1:0]   rdata;
    logic                   err;

    // Wishbone side
    logic                   wb_cyc;
    logic                   wb_stb;
    logic                   wb_we;
    logic [DataWidth/8-1:0] wb_sel;
    logic [AddrWidth-1:0]   wb_adr;
    logic [DataWidth-1:0]   wb_dat_o;
    logic [DataWidth-1:0]   wb_dat_i;
    logic                   wb_ack;
    logic                   wb_err;
    logic                   wb_stall;

    modport master (
        input  req, we, be, addr, wdata, wb_dat_i, wb_ack, wb_err, wb_stall,
        output gnt, rvalid, rdata, err, wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o
    );

    modport slave (
        output req, we, be, addr, wdata, wb_dat_i, wb_ack, wb_err, wb_stall,
        input  gnt, rvalid, rdata, err, wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o
    );
endinterface

// File: rtl/wb_obi_bridge.sv
// OBI (req/gnt/rvalid) to Wishbone B4 bridge, classic or pipelined, with an
// optional timeout that converts a hung bus into error responses.
module wb_obi_bridge #(
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned Pipelined      = 1,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned TimeoutCycles  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    wb_obi_bridge_if.master bus
);
    localparam int unsigned MaxOut  = (Pipelined != 0) ? MaxOutstanding : 1;
    localparam int unsigned OutstW  = $clog2(MaxOut + 1);
    localparam int unsigned TmoW    = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam int unsigned BeWidth = DataWidth / 8;

    // In pipelined mode StActive just means "something outstanding"; in classic
    // mode it is the cycle-holding phase that drives stb from captured request.
    typedef enum logic [1:0] {StIdle, StActive, StAbort} state_e;

    state_e                state_q, state_d;
    logic [OutstW-1:0]     outst_q, outst_d;
    logic [TmoW-1:0]       tmo_q, tmo_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;
    logic [DataWidth-1:0]  rdata_q;

    // Captured request, only driven onto the bus in classic mode
    logic                  we_q;
    logic [BeWidth-1:0]    sel_q;
    logic [AddrWidth-1:0]  adr_q;
    logic [DataWidth-1:0]  dat_q;

    logic abort, stb, cyc, gnt, bus_resp, resp;

    // Bus handshake decode: strobe, grant, cycle and accepted responses
    always_comb begin
        abort    = (state_q == StAbort);
        bus_resp = bus.wb_ack | bus.wb_err;
        if (Pipelined != 0) begin
            stb = bus.req & (outst_q < OutstW'(MaxOut)) & ~abort;
            gnt = stb & ~bus.wb_stall;
            cyc = stb | ((outst_q != '0) & ~abort);
        end else begin
            stb = (state_q == StActive);
            gnt = bus.req & (state_q == StIdle);
            cyc = stb;
        end
        // Responses with nothing outstanding, or during abort, are dropped
        resp = bus_resp & (outst_q != '0) & ~abort;
    end

    // Next state, outstanding count, timeout counter and response generation
    always_comb begin
        state_d  = state_q;
        outst_d  = outst_q;
        tmo_d    = '0;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        if (abort) begin
            // Drain: one error response per cycle for every abandoned transfer
            if (outst_q != '0) begin
                outst_d  = outst_q - 1'b1;
                rvalid_d = 1'b1;
                err_d    = 1'b1;
            end
            if (outst_d == '0) begin
                state_d = StIdle;
            end
        end else begin
            outst_d  = outst_q + OutstW'(gnt) - OutstW'(resp);
            rvalid_d = resp;
            err_d    = resp & bus.wb_err;
            if (!bus_resp && (outst_q != '0) && (TimeoutCycles != 0)) begin
                tmo_d = tmo_q + 1'b1;
            end
            state_d = (outst_d != '0) ? StActive : StIdle;
            if ((TimeoutCycles != 0) && (tmo_d == TmoW'(TimeoutCycles))) begin
                state_d = StAbort;
            end
        end
    end

    // Control and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            outst_q  <= '0;
            tmo_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            outst_q  <= outst_d;
            tmo_q    <= tmo_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            if (resp) begin
                rdata_q <= bus.wb_dat_i;
            end
        end
    end

    // Request capture on grant for the classic-mode bus phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q  <= 1'b0;
            sel_q <= '0;
            adr_q <= '0;
            dat_q <= '0;
        end else if (gnt) begin
            we_q  <= bus.we;
            sel_q <= bus.be;
            adr_q <= bus.addr;
            dat_q <= bus.wdata;
        end
    end

    assign bus.gnt      = gnt;
    assign bus.rvalid   = rvalid_q;
    assign bus.rdata    = rdata_q;
    assign bus.err      = err_q;
    assign bus.wb_cyc   = cyc;
    assign bus.wb_stb   = stb;
    assign bus.wb_we    = (Pipelined != 0) ? bus.we    : we_q;
    assign bus.wb_sel   = (Pipelined != 0) ? bus.be    : sel_q;
    assign bus.wb_adr   = (Pipelined != 0) ? bus.addr  : adr_q;
    assign bus.wb_dat_o = (Pipelined != 0) ? bus.wdata : dat_q;
endmodule

// File: tb/tb_wb_obi_bridge.sv
// Directed bench: a pipelined bridge (2 outstanding, 8-cycle timeout) and a
// classic bridge, driven cycle by cycle with hand-derived expectations.
module tb_wb_obi_bridge;
    logic        clk;
    logic        rst_n;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          ng;

    logic [10:0] t2_req, t2_ack, t2_gnt, t2_rv, t2_cyc;

    wb_obi_bridge_if #(.DataWidth(32), .AddrWidth(32)) p_if ();
    wb_obi_bridge_if #(.DataWidth(32), .AddrWidth(32)) c_if ();

    wb_obi_bridge #(
        .DataWidth      (32),
        .AddrWidth      (32),
        .Pipelined      (1),
        .MaxOutstanding (2),
        .TimeoutCycles  (8)
    ) u_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (p_if)
    );

    wb_obi_bridge #(
        .DataWidth      (32),
        .AddrWidth      (32),
        .Pipelined      (0),
        .MaxOutstanding (2),
        .TimeoutCycles  (0)
    ) u_cls (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (c_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_p_resp"}, {p_if.gnt, p_if.rvalid, p_if.err}, 0);
        check_eq({tag, "_p_rdata"}, p_if.rdata, 0);
        check_eq({tag, "_p_ctl"}, {p_if.wb_cyc, p_if.wb_stb, p_if.wb_we, p_if.wb_sel}, 0);
        check_eq({tag, "_p_adr"}, p_if.wb_adr, 0);
        check_eq({tag, "_p_dat"}, p_if.wb_dat_o, 0);
        check_eq({tag, "_c_resp"}, {c_if.gnt, c_if.rvalid, c_if.err}, 0);
        check_eq({tag, "_c_rdata"}, c_if.rdata, 0);
        check_eq({tag, "_c_ctl"}, {c_if.wb_cyc, c_if.wb_stb, c_if.wb_we, c_if.wb_sel}, 0);
        check_eq({tag, "_c_adr"}, c_if.wb_adr, 0);
        check_eq({tag, "_c_dat"}, c_if.wb_dat_o, 0);
    endtask

    // Move into the next cycle; inputs change 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic p_drive(input logic req, input logic [31:0] addr, input logic ack,
                           input logic berr, input logic stall, input logic [31:0] dat);
        p_if.req      = req;
        p_if.addr     = addr;
        p_if.wb_ack   = ack;
        p_if.wb_err   = berr;
        p_if.wb_stall = stall;
        p_if.wb_dat_i = dat;
    endtask

    initial begin
        rst_n = 1'b0;
        p_if.we = 1'b0;  p_if.be = '0;  p_if.wdata = '0;
        p_drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        c_if.req = 1'b0; c_if.we = 1'b0; c_if.be = '0; c_if.addr = '0; c_if.wdata = '0;
        c_if.wb_dat_i = '0; c_if.wb_ack = 1'b0; c_if.wb_err = 1'b0; c_if.wb_stall = 1'b0;

        t2_req = 11'b00000111111;
        t2_ack = 11'b00110011000;
        t2_gnt = 11'b00000110011;
        t2_rv  = 11'b01100110000;
        t2_cyc = 11'b00111111111;

        #2;
        check_all_zero("reset");
        #20;
        rst_n = 1'b1;

        // Back-to-back reads, slave acks one cycle after accept
        for (int i = 0; i < 7; i++) begin
            step();
            p_drive(i < 4, (i < 4) ? 32'(4 * i) : 32'h0, (i >= 1) && (i <= 4), 1'b0, 1'b0,
                    32'hA000_0000 | 32'(i));
            #1;
            if (i < 4) begin
                check_eq("b2b_gnt", p_if.gnt, 1);
                check_eq("b2b_adr", p_if.wb_adr, 4 * i);
            end
            check_eq("b2b_cyc", p_if.wb_cyc, i <= 4);
            check_eq("b2b_rvalid", p_if.rvalid, (i >= 2) && (i <= 5));
            if (i >= 2 && i <= 5) check_eq("b2b_rdata", p_if.rdata, 32'hA000_0000 | 32'(i - 1));
        end

        // Slave acks three cycles after accept, req held: window of two
        ng = 0;
        for (int i = 0; i < 11; i++) begin
            step();
            p_drive(t2_req[i], 32'h20 + 32'(4 * ng), t2_ack[i], 1'b0, 1'b0,
                    32'hB000_0000 | 32'(i));
            #1;
            check_eq("lat3_gnt", p_if.gnt, t2_gnt[i]);
            check_eq("lat3_stb", p_if.wb_stb, t2_gnt[i]);
            check_eq("lat3_cyc", p_if.wb_cyc, t2_cyc[i]);
            check_eq("lat3_rvalid", p_if.rvalid, t2_rv[i]);
            if (t2_rv[i]) check_eq("lat3_rdata", p_if.rdata, 32'hB000_0000 | 32'(i - 1));
            if (t2_gnt[i]) begin
                check_eq("lat3_adr", p_if.wb_adr, 32'h20 + 32'(4 * ng));
                ng++;
            end
        end

        // Stall for five cycles with req high
        for (int i = 0; i < 8; i++) begin
            step();
            p_drive(i <= 5, 32'h40, i == 6, 1'b0, i <= 4, 32'h0000_00C0);
            #1;
            if (i <= 5) begin
                check_eq("stall_gnt", p_if.gnt, i == 5);
                check_eq("stall_adr", p_if.wb_adr, 32'h40);
                check_eq("stall_stb", p_if.wb_stb, 1);
            end
            check_eq("stall_rvalid", p_if.rvalid, i == 7);
            if (i == 7) check_eq("stall_rdata", p_if.rdata, 32'h0000_00C0);
        end

        // Error on the second of two reads, then a spurious ack while idle
        for (int i = 0; i < 8; i++) begin
            step();
            p_drive((i <= 1) || (i == 5), 32'h50 + 32'(4 * i),
                    (i == 1) || (i == 2) || (i == 4) || (i == 6), i == 2, 1'b0,
                    32'h0000_0050 + 32'(i));
            #1;
            if (i <= 1 || i == 5) check_eq("err_gnt", p_if.gnt, 1);
            check_eq("err_rvalid", p_if.rvalid, (i == 2) || (i == 3) || (i == 7));
            if (i == 2 || i == 3 || i == 7) check_eq("err_flag", p_if.err, i == 3);
            if (i == 2) check_eq("err_rdata", p_if.rdata, 32'h51);
            if (i == 7) check_eq("err_rdata2", p_if.rdata, 32'h56);
            if (i == 4) check_eq("spur_cyc", p_if.wb_cyc, 0);
        end

        // Timeout: silent slave with two outstanding, then reset during abort
        for (int f = 0; f < 26; f++) begin
            step();
            p_drive((f <= 3) || (f == 11) || (f == 15) || (f == 16),
                    (f < 25) ? 32'h600 + 32'(4 * f) : 32'h0,
                    (f == 2) || (f == 12), 1'b0, 1'b0, 32'h0000_0600 + 32'(f));
            if (f == 25) rst_n = 1'b0;
            #1;
            if (f <= 1 || f == 3 || f == 15 || f == 16) check_eq("tmo_gnt", p_if.gnt, 1);
            if (f == 2 || f == 11) check_eq("tmo_nognt", p_if.gnt, 0);
            if (f == 3) check_eq("tmo_first_rsp", {p_if.rvalid, p_if.err}, 2'b10);
            if (f >= 3 && f <= 10) check_eq("tmo_cyc_held", p_if.wb_cyc, 1);
            if (f == 11 || f == 12 || f == 14 || f == 24) check_eq("tmo_cyc_low", p_if.wb_cyc, 0);
            if (f == 11) check_eq("tmo_abort_stb", p_if.wb_stb, 0);
            if (f == 23) check_eq("tmo2_cyc_held", p_if.wb_cyc, 1);
            if (f == 11 || f == 14) check_eq("tmo_no_rvalid", p_if.rvalid, 0);
            if (f == 12 || f == 13) check_eq("tmo_err_rsp", {p_if.rvalid, p_if.err}, 2'b11);
            if (f == 25) check_all_zero("abort_rst");
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            check_eq("post_rst", {p_if.rvalid, p_if.wb_cyc}, 0);
        end

        // Classic write then read; core inputs change while the bus phase holds
        for (int k = 0; k < 8; k++) begin
            step();
            c_if.req      = (k <= 4);
            c_if.we       = (k == 0);
            c_if.be       = (k == 0) ? 4'b0011 : 4'b1111;
            c_if.addr     = (k == 0) ? 32'h100 : 32'h200;
            c_if.wdata    = (k == 0) ? 32'hDEAD_BEEF : 32'h1234_5678;
            c_if.wb_ack   = (k == 3) || (k == 5);
            c_if.wb_stall = (k == 5);
            c_if.wb_dat_i = (k == 5) ? 32'hCAFE_0001 : 32'h0;
            #1;
            check_eq("cls_gnt", c_if.gnt, (k == 0) || (k == 4));
            check_eq("cls_cyc", {c_if.wb_cyc, c_if.wb_stb}, ((k >= 1 && k <= 3) || k == 5) ? 2'b11 : 2'b00);
            if (k >= 1 && k <= 3) begin
                check_eq("cls_wr_we", c_if.wb_we, 1);
                check_eq("cls_wr_sel", c_if.wb_sel, 4'b0011);
                check_eq("cls_wr_adr", c_if.wb_adr, 32'h100);
                check_eq("cls_wr_dat", c_if.wb_dat_o, 32'hDEAD_BEEF);
            end
            if (k == 5) begin
                check_eq("cls_rd_we", c_if.wb_we, 0);
                check_eq("cls_rd_adr", c_if.wb_adr, 32'h200);
            end
            check_eq("cls_rvalid", c_if.rvalid, (k == 4) || (k == 6));
            if (k == 4 || k == 6) check_eq("cls_err", c_if.err, 0);
            if (k == 6) check_eq("cls_rdata", c_if.rdata, 32'hCAFE_0001);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
